// File: rtl/hazard_forward_unit_if.sv
// Decode-to-execute forwarding interface: decode operand/destination info in,
// stall request and registered forward selects out.
interface hazard_forward_unit_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              flush;
  logic              stall;
  logic              EEforward1;
  logic              EEforward2;
  logic              ESEforward1;
  logic              ESEforward2;
  logic              MEforward1;
  logic              MEforward2;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_reg_write,
           id_mem_read, flush,
    input  stall, EEforward1, EEforward2, ESEforward1, ESEforward2, MEforward1,
           MEforward2, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_reg_write,
           id_mem_read, flush,
    output stall, EEforward1, EEforward2, ESEforward1, ESEforward2, MEforward1,
           MEforward2, stall_cnt
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// Tracks the last two issued destinations, registers execute forward selects,
// and raises a one-cycle load-use stall with a saturating stall counter.
module hazard_forward_unit #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input logic                  clk,
  input logic                  rst,
  hazard_forward_unit_if.slave bus
);

  logic              h1_valid_q, h1_rw_q, h1_mr_q;
  logic [REG_AW-1:0] h1_rd_q;
  logic              h2_valid_q, h2_rw_q, h2_mr_q;
  logic [REG_AW-1:0] h2_rd_q;

  logic [1:0]        ee_q, ese_q, me_q;
  logic [1:0]        ee_d, ese_d, me_d;
  logic [CNT_W-1:0]  cnt_q;

  logic [1:0][REG_AW-1:0] rs;
  logic [1:0]             use_rs;
  logic                   hz;
  logic                   stall;

  // x0 is hardwired zero, so it never matches a producer.
  function automatic logic slot_writes(input logic v, input logic rw,
                                       input logic [REG_AW-1:0] rd,
                                       input logic [REG_AW-1:0] r);
    return v & rw & (rd == r) & (r != '0);
  endfunction

  assign rs     = {bus.id_rs2, bus.id_rs1};
  assign use_rs = {bus.id_use_rs2, bus.id_use_rs1};

  always_comb begin
    ee_d  = '0;
    ese_d = '0;
    me_d  = '0;
    hz    = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (bus.id_valid && use_rs[k]) begin
        if (slot_writes(h1_valid_q, h1_rw_q, h1_rd_q, rs[k])) begin
          if (h1_mr_q) hz = 1'b1;
          else         ee_d[k] = 1'b1;
        end else if (slot_writes(h2_valid_q, h2_rw_q, h2_rd_q, rs[k])) begin
          if (h2_mr_q) me_d[k]  = 1'b1;
          else         ese_d[k] = 1'b1;
        end
      end
    end
  end

  assign stall = hz & ~bus.flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h1_valid_q <= 1'b0;
      h1_rw_q    <= 1'b0;
      h1_mr_q    <= 1'b0;
      h1_rd_q    <= '0;
      h2_valid_q <= 1'b0;
      h2_rw_q    <= 1'b0;
      h2_mr_q    <= 1'b0;
      h2_rd_q    <= '0;
      ee_q       <= '0;
      ese_q      <= '0;
      me_q       <= '0;
      cnt_q      <= '0;
    end else begin
      h2_valid_q <= h1_valid_q;
      h2_rw_q    <= h1_rw_q;
      h2_mr_q    <= h1_mr_q;
      h2_rd_q    <= h1_rd_q;
      if (bus.flush || stall) begin
        // Killed or held instruction enters execute as a bubble.
        h1_valid_q <= 1'b0;
        h1_rw_q    <= 1'b0;
        h1_mr_q    <= 1'b0;
        h1_rd_q    <= '0;
        ee_q       <= '0;
        ese_q      <= '0;
        me_q       <= '0;
        if (stall && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
      end else begin
        h1_valid_q <= bus.id_valid;
        h1_rw_q    <= bus.id_reg_write;
        h1_mr_q    <= bus.id_mem_read;
        h1_rd_q    <= bus.id_rd;
        ee_q       <= ee_d;
        ese_q      <= ese_d;
        me_q       <= me_d;
      end
    end
  end

  assign bus.stall       = stall;
  assign bus.EEforward1  = ee_q[0];
  assign bus.EEforward2  = ee_q[1];
  assign bus.ESEforward1 = ese_q[0];
  assign bus.ESEforward2 = ese_q[1];
  assign bus.MEforward1  = me_q[0];
  assign bus.MEforward2  = me_q[1];
  assign bus.stall_cnt   = cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench for hazard_forward_unit; a narrow counter keeps the
// saturation run short.
module tb_hazard_forward_unit;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned CNT_W  = 8;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  typedef struct {
    string            tag;
    logic [5:0]       fwd;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  hazard_forward_unit_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

  hazard_forward_unit #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // {EE1, EE2, ESE1, ESE2, ME1, ME2}
  function automatic logic [5:0] fwd_now();
    return {bus.EEforward1, bus.EEforward2, bus.ESEforward1, bus.ESEforward2,
            bus.MEforward1, bus.MEforward2};
  endfunction

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic fl);
    bus.id_valid     = v;
    bus.id_rs1       = rs1;
    bus.id_rs2       = rs2;
    bus.id_use_rs1   = u1;
    bus.id_use_rs2   = u2;
    bus.id_rd        = rd;
    bus.id_reg_write = rw;
    bus.id_mem_read  = mr;
    bus.flush        = fl;
  endtask

  task automatic step(input string tag, input logic v, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic u1, input logic u2,
                      input logic [4:0] rd, input logic rw, input logic mr, input logic fl,
                      input logic exp_stall, input logic [5:0] exp_fwd, input int exp_cnt);
    exp_t e;
    logic [5:0] f;
    @(negedge clk);
    drive(v, rs1, rs2, u1, u2, rd, rw, mr, fl);
    #1;
    check_eq({tag, ".stall"}, {31'd0, bus.stall}, {31'd0, exp_stall});
    e.tag = tag;
    e.fwd = exp_fwd;
    e.cnt = exp_cnt[CNT_W-1:0];
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      f = fwd_now();
      check_eq({e.tag, ".fwd"}, {26'd0, f}, {26'd0, e.fwd});
      check_eq({e.tag, ".cnt"}, {{(32-CNT_W){1'b0}}, bus.stall_cnt},
               {{(32-CNT_W){1'b0}}, e.cnt});
      check_eq({e.tag, ".onehot"},
               {31'd0, ($countones({f[5], f[3], f[1]}) <= 1) &&
                       ($countones({f[4], f[2], f[0]}) <= 1)}, 32'd1);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    check_eq("rst.fwd", {26'd0, fwd_now()}, 32'd0);
    check_eq("rst.stall", {31'd0, bus.stall}, 32'd0);
    check_eq("rst.cnt", {24'd0, bus.stall_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    //   tag          v rs1 rs2 u1 u2 rd rw mr fl  stall fwd        cnt
    step("addi_x1",   1, 0,  0,  1, 0, 1, 1, 0, 0, 0, 6'b000000, 0);
    step("add_x1x1",  1, 1,  1,  1, 1, 2, 1, 0, 0, 0, 6'b110000, 0);
    step("addi_x3",   1, 0,  0,  1, 0, 3, 1, 0, 0, 0, 6'b000000, 0);
    step("nop",       1, 0,  0,  1, 0, 0, 1, 0, 0, 0, 6'b000000, 0);
    step("sub_x3x0",  1, 3,  0,  1, 1, 4, 1, 0, 0, 0, 6'b001000, 0);
    step("lw_x5",     1, 10, 0,  1, 0, 5, 1, 1, 0, 0, 6'b000000, 0);
    step("use_x5",    1, 5,  7,  1, 1, 6, 1, 0, 0, 1, 6'b000000, 1);
    step("use_x5_me", 1, 5,  7,  1, 1, 6, 1, 0, 0, 0, 6'b000010, 1);
    step("lw_x11",    1, 0,  0,  1, 0, 11, 1, 1, 0, 0, 6'b000000, 1);
    step("flush_use", 1, 11, 6,  1, 1, 12, 1, 0, 1, 0, 6'b000000, 1);
    step("wr_x0",     1, 1,  0,  1, 0, 0, 1, 0, 0, 0, 6'b000000, 1);
    step("rd_x0",     1, 0,  0,  1, 1, 13, 1, 0, 0, 0, 6'b000000, 1);
    step("addi_x8a",  1, 0,  0,  1, 0, 8, 1, 0, 0, 0, 6'b000000, 1);
    step("addi_x8b",  1, 8,  0,  1, 0, 8, 1, 0, 0, 0, 6'b100000, 1);
    step("add_x8x8",  1, 8,  8,  1, 1, 9, 1, 0, 0, 0, 6'b110000, 1);
    step("lw_x14",    1, 0,  0,  1, 0, 14, 1, 1, 0, 0, 6'b000000, 1);
    step("lw_dep",    1, 14, 0,  1, 0, 15, 1, 1, 0, 1, 6'b000000, 2);
    step("lw_dep_me", 1, 14, 0,  1, 0, 15, 1, 1, 0, 0, 6'b000010, 2);
    step("invalid",   0, 15, 0,  1, 0, 0, 0, 0, 0, 0, 6'b000000, 2);
    step("me_rs2",    1, 0,  15, 1, 1, 16, 1, 0, 0, 0, 6'b000001, 2);
    step("addi_x17",  1, 0,  0,  1, 0, 17, 1, 0, 0, 0, 6'b000000, 2);
    step("ese_rs2",   1, 0,  16, 1, 1, 18, 1, 0, 0, 0, 6'b000100, 2);
    step("imm_rs2",   1, 18, 18, 1, 0, 19, 1, 0, 0, 0, 6'b100000, 2);
    step("lw_x20",    1, 19, 0,  1, 0, 20, 1, 1, 0, 0, 6'b100000, 2);

    // Asynchronous reset while a load-use stall is pending.
    @(negedge clk);
    drive(1, 20, 0, 1, 1, 21, 1, 0, 0);
    #1;
    check_eq("pre_rst.stall", {31'd0, bus.stall}, 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check_eq("mid_rst.stall", {31'd0, bus.stall}, 32'd0);
    check_eq("mid_rst.fwd", {26'd0, fwd_now()}, 32'd0);
    check_eq("mid_rst.cnt", {24'd0, bus.stall_cnt}, 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    // 2^CNT_W stall events: the last one must leave the counter saturated.
    for (int i = 0; i < (1 << CNT_W); i++) begin
      step("sat_ld",  1, 0, 0, 1, 0, 1, 1, 1, 0, 0, 6'b000000, i);
      step("sat_use", 1, 1, 0, 1, 0, 2, 1, 0, 0, 1, 6'b000000,
           (i + 1 > 255) ? 255 : i + 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
